// File: rtl/split_pkg.sv
// Shared types for the split verdict collector: FSM states, default split
// count and the registered verdict record.
package split_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    REPORT  = 1'b1
  } collect_state_t;

  localparam int SPLIT_NUM_DEFAULT = 32;

  // Wide enough for any index of the largest legal split count (256).
  localparam int SPLIT_IDX_MAX_W = 8;

  typedef struct packed {
    logic                       sat;
    logic                       err;
    logic [SPLIT_IDX_MAX_W-1:0] fail_idx;
  } verdict_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over
// the increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count register: clear first, then increment unless already at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/split_verdict_collector.sv
// Collects one x bit per split for each candidate assignment, AND-reduces
// them, checks split coverage and reports one verdict per candidate.
module split_verdict_collector
  import split_pkg::*;
#(
  parameter int NUM_SPLITS = SPLIT_NUM_DEFAULT,
  parameter int IDX_W      = $clog2(NUM_SPLITS),
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_x,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat,
  output logic             out_err,
  output logic [IDX_W-1:0] out_fail_idx,
  output logic [CNT_W-1:0] cand_count,
  output logic [CNT_W-1:0] sat_count,
  input  logic             clear
);

  localparam logic [31:0]           NUM_SPLITS_U = 32'(NUM_SPLITS);
  localparam logic [NUM_SPLITS-1:0] ONE_HOT_BASE = {{(NUM_SPLITS-1){1'b0}}, 1'b1};

  collect_state_t          state_r, state_nxt_s;
  logic                    acc_r, acc_nxt_s;
  logic [NUM_SPLITS-1:0]   seen_r, seen_nxt_s;
  logic                    dup_r, dup_nxt_s;
  logic                    range_err_r, range_err_nxt_s;
  logic                    fail_seen_r, fail_seen_nxt_s;
  logic [IDX_W-1:0]        fail_idx_r, fail_idx_nxt_s;
  verdict_t                verdict_r, verdict_nxt_s;
  logic                    load_s;
  logic                    handshake_s;
  logic                    in_range_s;
  logic [NUM_SPLITS-1:0]   idx_onehot_s;
  logic                    seen_hit_s;
  logic                    err_s;

  // An out-of-range index shifts the bit out entirely, so it never marks seen.
  assign in_range_s   = (32'(in_idx) < NUM_SPLITS_U);
  assign idx_onehot_s = ONE_HOT_BASE << in_idx;
  assign seen_hit_s   = |(seen_r & idx_onehot_s);

  // Next-state and accumulator update for the COLLECT/REPORT handshake FSM.
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    seen_nxt_s      = seen_r;
    dup_nxt_s       = dup_r;
    range_err_nxt_s = range_err_r;
    fail_seen_nxt_s = fail_seen_r;
    fail_idx_nxt_s  = fail_idx_r;
    load_s          = 1'b0;
    handshake_s     = 1'b0;
    case (state_r)
      COLLECT: begin
        if (in_valid) begin
          acc_nxt_s       = acc_r & (in_x | ~in_range_s);
          seen_nxt_s      = seen_r | idx_onehot_s;
          dup_nxt_s       = dup_r | seen_hit_s;
          range_err_nxt_s = range_err_r | ~in_range_s;
          if (!in_x && !fail_seen_r) begin
            fail_idx_nxt_s  = in_idx;
            fail_seen_nxt_s = 1'b1;
          end else begin
            fail_idx_nxt_s  = fail_idx_r;
            fail_seen_nxt_s = fail_seen_r;
          end
          if (in_last) begin
            state_nxt_s = REPORT;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = COLLECT;
          end
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      REPORT: begin
        if (out_ready) begin
          state_nxt_s     = COLLECT;
          handshake_s     = 1'b1;
          acc_nxt_s       = 1'b1;
          seen_nxt_s      = {NUM_SPLITS{1'b0}};
          dup_nxt_s       = 1'b0;
          range_err_nxt_s = 1'b0;
          fail_seen_nxt_s = 1'b0;
          fail_idx_nxt_s  = {IDX_W{1'b0}};
        end else begin
          state_nxt_s = REPORT;
        end
      end
      default: begin
        state_nxt_s = COLLECT;
      end
    endcase
  end

  // Verdict formed from the post-update accumulators so the last beat counts.
  always_comb begin
    err_s                  = dup_nxt_s | range_err_nxt_s | ~(&seen_nxt_s);
    verdict_nxt_s.sat      = acc_nxt_s & ~err_s;
    verdict_nxt_s.err      = err_s;
    verdict_nxt_s.fail_idx = SPLIT_IDX_MAX_W'(fail_idx_nxt_s);
  end

  // FSM state, accumulators and the held verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= COLLECT;
      acc_r       <= 1'b1;
      seen_r      <= {NUM_SPLITS{1'b0}};
      dup_r       <= 1'b0;
      range_err_r <= 1'b0;
      fail_seen_r <= 1'b0;
      fail_idx_r  <= {IDX_W{1'b0}};
      verdict_r   <= '{sat: 1'b0, err: 1'b0, fail_idx: {SPLIT_IDX_MAX_W{1'b0}}};
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      seen_r      <= seen_nxt_s;
      dup_r       <= dup_nxt_s;
      range_err_r <= range_err_nxt_s;
      fail_seen_r <= fail_seen_nxt_s;
      fail_idx_r  <= fail_idx_nxt_s;
      if (load_s) begin
        verdict_r <= verdict_nxt_s;
      end else begin
        verdict_r <= verdict_r;
      end
    end
  end

  assign in_ready     = (state_r == COLLECT);
  assign out_valid    = (state_r == REPORT);
  assign out_sat      = verdict_r.sat;
  assign out_err      = verdict_r.err;
  assign out_fail_idx = IDX_W'(verdict_r.fail_idx);

  sat_counter #(.CNT_W(CNT_W)) u_cand_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handshake_s),
    .clr   (clear),
    .count (cand_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_sat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handshake_s & verdict_r.sat),
    .clr   (clear),
    .count (sat_count)
  );

endmodule

// File: tb/tb_split_verdict_collector.sv
// Scoreboard bench for split_verdict_collector: directed candidates push
// hand-computed verdicts; a negedge monitor pops and compares on handshakes.
module tb_split_verdict_collector;

  localparam int IW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_x, in_last;
  logic [IW-1:0] in_idx;
  logic          out_valid, out_ready, out_sat, out_err;
  logic [IW-1:0] out_fail_idx;
  logic [CW-1:0] cand_count, sat_count;
  logic          clear;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic sat;
    logic err;
    int   fail_idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  split_verdict_collector #(.NUM_SPLITS(32), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_idx       (in_idx),
    .in_x         (in_x),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sat      (out_sat),
    .out_err      (out_err),
    .out_fail_idx (out_fail_idx),
    .cand_count   (cand_count),
    .sat_count    (sat_count),
    .clear        (clear)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_verdict(input logic s, input logic e, input int f);
    exp_t v;
    v.sat      = s;
    v.err      = e;
    v.fail_idx = f;
    exp_q.push_back(v);
  endtask

  // Drive one beat starting just after a rising edge; returns just after the accepting edge.
  task automatic beat(input int idx, input logic x, input logic last);
    logic rdy;
    int   waits;
    in_valid = 1'b1;
    in_idx   = IW'(idx);
    in_x     = x;
    in_last  = last;
    waits    = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 20) begin
        check("beat_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic after_last();
    int n;
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    n = 0;
    while (out_valid === 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  // Monitor: every handshake must match the oldest expected verdict.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_verdict actual=present required=none");
      end else begin
        mon_e = exp_q.pop_front();
        check("out_sat", {31'd0, out_sat}, {31'd0, mon_e.sat});
        check("out_err", {31'd0, out_err}, {31'd0, mon_e.err});
        check("out_fail_idx", {27'd0, out_fail_idx}, 32'(mon_e.fail_idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_idx    = '0;
    in_x      = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    clear     = 1'b0;
    #23;
    rst_n = 1'b1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_out_fail_idx", {27'd0, out_fail_idx}, 32'd0);
    check("rst_cand_count", {16'd0, cand_count}, 32'd0);
    check("rst_sat_count", {16'd0, sat_count}, 32'd0);
    @(posedge clk);
    #1;

    // All splits in order, all satisfied.
    expect_verdict(1'b1, 1'b0, 0);
    for (int i = 0; i < 32; i++) beat(i, 1'b1, i == 31);
    after_last();
    check("t1_cand_count", {16'd0, cand_count}, 32'd1);
    check("t1_sat_count", {16'd0, sat_count}, 32'd1);

    // Reverse order, failures at 17 then 5: first in arrival order is 17.
    expect_verdict(1'b0, 1'b0, 17);
    for (int i = 31; i >= 0; i--) beat(i, (i == 17 || i == 5) ? 1'b0 : 1'b1, i == 0);
    after_last();
    check("t2_cand_count", {16'd0, cand_count}, 32'd2);
    check("t2_sat_count", {16'd0, sat_count}, 32'd1);

    // Index 9 twice, index 10 missing.
    expect_verdict(1'b0, 1'b1, 0);
    for (int k = 0; k < 32; k++) begin
      int idx;
      idx = (k == 10) ? 9 : k;
      beat(idx, 1'b1, k == 31);
    end
    after_last();
    check("t3_cand_count", {16'd0, cand_count}, 32'd3);
    check("t3_sat_count", {16'd0, sat_count}, 32'd1);

    // Back-pressure: out_ready low for 5 cycles while a new beat waits.
    out_ready = 1'b0;
    expect_verdict(1'b0, 1'b0, 3);
    for (int i = 0; i < 32; i++) beat(i, (i == 3) ? 1'b0 : 1'b1, i == 31);
    check("t4_latency", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    in_idx   = '0;
    in_x     = 1'b1;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out_sat", {31'd0, out_sat}, 32'd0);
      check("stall_out_err", {31'd0, out_err}, 32'd0);
      check("stall_fail_idx", {27'd0, out_fail_idx}, 32'd3);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    expect_verdict(1'b1, 1'b0, 0);
    for (int i = 0; i < 32; i++) beat(i, 1'b1, i == 31);
    after_last();
    check("t4_cand_count", {16'd0, cand_count}, 32'd5);
    check("t4_sat_count", {16'd0, sat_count}, 32'd2);

    // Saturation from 16'hFFFE, then clear coinciding with a handshake.
    force dut.u_cand_cnt.count_r = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.u_cand_cnt.count_r;
    for (int n = 0; n < 3; n++) begin
      expect_verdict(1'b0, 1'b1, 0);
      beat(0, 1'b1, 1'b1);
      after_last();
    end
    check("sat_cand_count", {16'd0, cand_count}, 32'h0000_FFFF);
    check("sat_sat_count", {16'd0, sat_count}, 32'd2);
    expect_verdict(1'b0, 1'b1, 0);
    beat(0, 1'b1, 1'b1);
    check("clr_latency", {31'd0, out_valid}, 32'd1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_cand_count", {16'd0, cand_count}, 32'd0);
    check("clr_sat_count", {16'd0, sat_count}, 32'd0);
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset pulse after beat 12 (held in REPORT) discards the verdict.
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) beat(i, (i == 4) ? 1'b0 : 1'b1, 1'b0);
    beat(12, 1'b1, 1'b1);
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_verdict(1'b1, 1'b0, 0);
    for (int i = 0; i < 32; i++) beat(i, 1'b1, i == 31);
    after_last();
    check("t6_cand_count", {16'd0, cand_count}, 32'd1);
    check("t6_sat_count", {16'd0, sat_count}, 32'd1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
